// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port ram (registered, 1-cycle read) between requester A
//   (USB-side buffer logic) and requester B (application-side logic).
//   Round-robin arbitration with a bounded burst: an owner keeps the ram for at
//   most BURST_MAX consecutive grants while the other side is also requesting.
//   Owner switches cost no idle cycle.
//
// Ports
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   a_req_i / b_req_i      access request for this cycle
//   a_we_i  / b_we_i       1 = write, 0 = read
//   a_addr_i / b_addr_i    word address
//   a_mask_i / b_mask_i    write mask, a 1 bit protects that ram bit
//   a_wdata_i / b_wdata_i  write data
//   a_gnt_o / b_gnt_o      request accepted this cycle (combinational)
//   a_rvalid_o/b_rvalid_o  read data valid, one cycle after a granted read
//   a_rdata_o / b_rdata_o  read data, forced to zero when not valid
//   ram_*_o / ram_rdata_i  interface to the shared ram
//
// Configuration
//   RAM_ARB_FIXED_PRIO_EN  when defined, A has strict priority over B and the
//                          burst limit / last-owner tracking no longer affect
//                          grants. Undefined by default (round-robin).
module ram_arbiter #(
  parameter int VECTOR_LENGTH = 256,
  parameter int WORD_WIDTH    = 16,
  parameter int BURST_MAX     = 4,
  parameter int ADDR_WIDTH    = $clog2(VECTOR_LENGTH)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  a_req_i,
  input  logic                  a_we_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [WORD_WIDTH-1:0] a_mask_i,
  input  logic [WORD_WIDTH-1:0] a_wdata_i,
  output logic                  a_gnt_o,
  output logic                  a_rvalid_o,
  output logic [WORD_WIDTH-1:0] a_rdata_o,
  input  logic                  b_req_i,
  input  logic                  b_we_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [WORD_WIDTH-1:0] b_mask_i,
  input  logic [WORD_WIDTH-1:0] b_wdata_i,
  output logic                  b_gnt_o,
  output logic                  b_rvalid_o,
  output logic [WORD_WIDTH-1:0] b_rdata_o,
  output logic                  ram_clke_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [WORD_WIDTH-1:0] ram_mask_o,
  output logic [WORD_WIDTH-1:0] ram_wdata_o,
  input  logic [WORD_WIDTH-1:0] ram_rdata_i
);

  localparam int CNT_WIDTH = $clog2(BURST_MAX + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(BURST_MAX);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_e;

  owner_e                 owner_q, owner_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   last_q, last_d;
  // bit 1 = A has a read in flight, bit 0 = B has a read in flight
  logic [1:0]             rd_owner_q, rd_owner_d;
  logic                   gntA, gntB;

  // Grant decision. Only one side can ever be granted per cycle; in IDLE a
  // tie goes to whichever side did not own the ram last.
  always_comb begin
    gntA = 1'b0;
    gntB = 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    gntA = a_req_i;
    gntB = b_req_i & ~a_req_i;
`else
    case (owner_q)
      IDLE: begin
        if (a_req_i && b_req_i) begin
          gntA = (last_q == SIDE_B);
          gntB = (last_q == SIDE_A);
        end else begin
          gntA = a_req_i;
          gntB = b_req_i;
        end
      end
      OWN_A: begin
        if (a_req_i && ((cnt_q < CNT_MAX) || !b_req_i)) gntA = 1'b1;
        else                                            gntB = b_req_i;
      end
      OWN_B: begin
        if (b_req_i && ((cnt_q < CNT_MAX) || !a_req_i)) gntB = 1'b1;
        else                                            gntA = a_req_i;
      end
      default: begin
        gntA = 1'b0;
        gntB = 1'b0;
      end
    endcase
`endif
  end

  // Next owner, burst count and last owner follow directly from the grant.
  // The count saturates so a lone requester can hold the ram indefinitely.
  always_comb begin
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    rd_owner_d = {gntA & ~a_we_i, gntB & ~b_we_i};
    if (gntA) begin
      owner_d = OWN_A;
      last_d  = SIDE_A;
      if (owner_q == OWN_A) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      else                  cnt_d = CNT_ONE;
    end else if (gntB) begin
      owner_d = OWN_B;
      last_d  = SIDE_B;
      if (owner_q == OWN_B) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      else                  cnt_d = CNT_ONE;
    end else begin
      owner_d = IDLE;
      cnt_d   = '0;
    end
  end

  // State registers; last_q resets to B so A wins the first tie.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      owner_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= SIDE_B;
      rd_owner_q <= 2'b00;
    end else begin
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Grants are forced low while reset is held so the ram sees no access.
  assign a_gnt_o    = gntA & rstn_i;
  assign b_gnt_o    = gntB & rstn_i;
  assign ram_clke_o = a_gnt_o | b_gnt_o;

  // Ram bus comes from the granted side, all zero otherwise.
  always_comb begin
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_mask_o  = '0;
    ram_wdata_o = '0;
    if (a_gnt_o) begin
      ram_we_o    = a_we_i;
      ram_addr_o  = a_addr_i;
      ram_mask_o  = a_mask_i;
      ram_wdata_o = a_wdata_i;
    end else if (b_gnt_o) begin
      ram_we_o    = b_we_i;
      ram_addr_o  = b_addr_i;
      ram_mask_o  = b_mask_i;
      ram_wdata_o = b_wdata_i;
    end
  end

  assign a_rvalid_o = rd_owner_q[1] & rstn_i;
  assign b_rvalid_o = rd_owner_q[0] & rstn_i;
  assign a_rdata_o  = a_rvalid_o ? ram_rdata_i : '0;
  assign b_rdata_o  = b_rvalid_o ? ram_rdata_i : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed vectors drive both requesters through a
// behavioural single-port ram; grants and the ram bus are compared every
// driven cycle, and read returns are compared by a scoreboard monitor.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        aReq = 1'b0, aWe = 1'b0, bReq = 1'b0, bWe = 1'b0;
  logic [7:0]  aAddr = '0, bAddr = '0;
  logic [15:0] aMask = '0, aWdata = '0, bMask = '0, bWdata = '0;
  logic        aGnt, aRvalid, bGnt, bRvalid;
  logic [15:0] aRdata, bRdata;
  logic        ramClke, ramWe;
  logic [7:0]  ramAddr;
  logic [15:0] ramMask, ramWdata;
  logic [15:0] ramRdata = '0;
  logic [15:0] mem [256];

  typedef struct {
    logic        side;
    logic [15:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t rdQ[$];
  int      checkCount = 0;
  int      passCount  = 0;
  int      cycleCnt   = 0;

  ram_arbiter dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .a_req_i    (aReq),
    .a_we_i     (aWe),
    .a_addr_i   (aAddr),
    .a_mask_i   (aMask),
    .a_wdata_i  (aWdata),
    .a_gnt_o    (aGnt),
    .a_rvalid_o (aRvalid),
    .a_rdata_o  (aRdata),
    .b_req_i    (bReq),
    .b_we_i     (bWe),
    .b_addr_i   (bAddr),
    .b_mask_i   (bMask),
    .b_wdata_i  (bWdata),
    .b_gnt_o    (bGnt),
    .b_rvalid_o (bRvalid),
    .b_rdata_o  (bRdata),
    .ram_clke_o (ramClke),
    .ram_we_o   (ramWe),
    .ram_addr_o (ramAddr),
    .ram_mask_o (ramMask),
    .ram_wdata_o(ramWdata),
    .ram_rdata_i(ramRdata)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to check read-return latency.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Behavioural ram: registered read, mask bit = 1 protects that bit.
  always @(posedge clk) begin
    if (ramClke) begin
      if (ramWe) mem[ramAddr] <= (mem[ramAddr] & ramMask) | (ramWdata & ~ramMask);
      else       ramRdata <= mem[ramAddr];
    end
  end

  // Single comparison point; every check goes through here.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Drive one cycle of requests, then check grants and the ram bus.
  // expGnt is {A,B}; a granted read queues its expected return data.
  task automatic applyStimulus(
    input logic aR, input logic aW, input logic [7:0] aA, input logic [15:0] aM, input logic [15:0] aD,
    input logic bR, input logic bW, input logic [7:0] bA, input logic [15:0] bM, input logic [15:0] bD,
    input logic [1:0] expGnt, input bit pushRd, input logic [15:0] expRd, input string tag);
    logic [40:0] expBus;
    rd_exp_t     e;
    @(negedge clk);
    aReq = aR; aWe = aW; aAddr = aA; aMask = aM; aWdata = aD;
    bReq = bR; bWe = bW; bAddr = bA; bMask = bM; bWdata = bD;
    #1;
    checkOutput({tag, "_gnt"}, {62'b0, aGnt, bGnt}, {62'b0, expGnt});
    checkOutput({tag, "_clke"}, {63'b0, ramClke}, {63'b0, expGnt != 2'b00});
    expBus = '0;
    if (expGnt == 2'b10)      expBus = {aW, aA, aM, aD};
    else if (expGnt == 2'b01) expBus = {bW, bA, bM, bD};
    checkOutput({tag, "_rambus"}, {23'b0, ramWe, ramAddr, ramMask, ramWdata}, {23'b0, expBus});
    if (pushRd && expGnt != 2'b00) begin
      e.side = (expGnt == 2'b01);
      e.data = expRd;
      e.due  = cycleCnt + 1;
      rdQ.push_back(e);
    end
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 8'h00, 16'h0000, 16'h0000, 2'b00, 0, 16'h0, tag);
  endtask

  task automatic releaseReset();
    aReq = 1'b0;
    bReq = 1'b0;
    rstn = 1'b1;
  endtask

  // Read-return monitor: pops the scoreboard whenever an rvalid appears and
  // flags returns that arrive late, early, on the wrong side or not at all.
  always @(negedge clk) begin
    rd_exp_t e;
    if (!aRvalid) checkOutput("a_rdata_gate", {48'b0, aRdata}, 64'h0);
    if (!bRvalid) checkOutput("b_rdata_gate", {48'b0, bRdata}, 64'h0);
    if (aRvalid || bRvalid) begin
      if (rdQ.size() == 0) begin
        checkOutput("unexpected_rvalid", {62'b0, aRvalid, bRvalid}, 64'h0);
      end else begin
        e = rdQ.pop_front();
        checkOutput("rvalid_side", {62'b0, aRvalid, bRvalid}, e.side ? 64'h1 : 64'h2);
        checkOutput("rdata", {48'b0, (e.side ? bRdata : aRdata)}, {48'b0, e.data});
        checkOutput("rvalid_cycle", 64'(cycleCnt), 64'(e.due));
      end
    end else if (rdQ.size() > 0 && rdQ[0].due <= cycleCnt) begin
      e = rdQ.pop_front();
      checkOutput("missing_rvalid", {62'b0, aRvalid, bRvalid}, e.side ? 64'h1 : 64'h2);
    end
  end

  initial begin
    logic [1:0] expG;

    // Reset held with random requests: nothing may be granted.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'h05, 16'h0, 16'h0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'h06, 16'h0, 16'h0,
                    2'b00, 0, 16'h0, "t1_rst");
    end
    releaseReset();

    // Both requesting continuously (fully masked writes leave the ram alone).
    // Round-robin: AAAA BBBB AAAA; fixed priority: A throughout. Then A drops.
    for (int i = 0; i < 12; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      expG = 2'b10;
`else
      expG = (((i / 4) % 2) == 0) ? 2'b10 : 2'b01;
`endif
      applyStimulus(1, 1, 8'(i), 16'hFFFF, 16'h0, 1, 1, 8'(i + 100), 16'hFFFF, 16'h0,
                    expG, 0, 16'h0, "t3_burst");
    end
    applyStimulus(0, 1, 8'h00, 16'hFFFF, 16'h0, 1, 1, 8'h77, 16'hFFFF, 16'h0, 2'b01, 0, 16'h0, "t6_adrop");
    idleCycle("idle0");

    // A write then read back.
    applyStimulus(1, 1, 8'h10, 16'h0000, 16'hBEEF, 0, 0, 8'h00, 16'h0, 16'h0, 2'b10, 0, 16'h0, "t2_wr");
    applyStimulus(1, 0, 8'h10, 16'h0000, 16'h0000, 0, 0, 8'h00, 16'h0, 16'h0, 2'b10, 1, 16'hBEEF, "t2_rd");
    idleCycle("idle1");

    // Masked write from B over an all-ones word.
    applyStimulus(1, 1, 8'h30, 16'h0000, 16'hFFFF, 0, 0, 8'h00, 16'h0, 16'h0, 2'b10, 0, 16'h0, "t4_fill");
    applyStimulus(0, 0, 8'h00, 16'h0000, 16'h0000, 1, 1, 8'h30, 16'hFF00, 16'h1234, 2'b01, 0, 16'h0, "t4_mwr");
    applyStimulus(0, 0, 8'h00, 16'h0000, 16'h0000, 1, 0, 8'h30, 16'h0000, 16'h0000, 2'b01, 1, 16'hFF34, "t4_rd");

    // Back-to-back reads alternating between owners.
    applyStimulus(1, 1, 8'h20, 16'h0000, 16'h1111, 0, 0, 8'h00, 16'h0, 16'h0, 2'b10, 0, 16'h0, "alt_wa");
    applyStimulus(0, 0, 8'h00, 16'h0000, 16'h0000, 1, 1, 8'h21, 16'h0000, 16'h2222, 2'b01, 0, 16'h0, "alt_wb");
    applyStimulus(1, 0, 8'h20, 16'h0000, 16'h0000, 0, 0, 8'h00, 16'h0, 16'h0, 2'b10, 1, 16'h1111, "alt_ra");
    applyStimulus(0, 0, 8'h00, 16'h0000, 16'h0000, 1, 0, 8'h21, 16'h0000, 16'h0000, 2'b01, 1, 16'h2222, "alt_rb");
    applyStimulus(1, 0, 8'h21, 16'h0000, 16'h0000, 0, 0, 8'h00, 16'h0, 16'h0, 2'b10, 1, 16'h2222, "alt_ra2");
    idleCycle("idle2");

    // Tie from IDLE after A owned last: B wins unless A has fixed priority.
`ifdef RAM_ARB_FIXED_PRIO_EN
    expG = 2'b10;
`else
    expG = 2'b01;
`endif
    applyStimulus(1, 1, 8'h40, 16'hFFFF, 16'h0, 1, 1, 8'h41, 16'hFFFF, 16'h0, expG, 0, 16'h0, "tie_idle");
    idleCycle("idle3");

    // A granted B read is cut off by reset: no return, arbiter back to IDLE
    // with A winning the next tie (B would keep it if the state survived).
    applyStimulus(0, 0, 8'h00, 16'h0000, 16'h0000, 1, 0, 8'h10, 16'h0000, 16'h0000, 2'b01, 0, 16'h0, "t5_rd");
    @(posedge clk);
    #1 rstn = 1'b0;
    applyStimulus(1, 1, 8'h50, 16'hFFFF, 16'h0, 1, 1, 8'h51, 16'hFFFF, 16'h0, 2'b00, 0, 16'h0, "t5_rst");
    applyStimulus(1, 0, 8'h50, 16'h0000, 16'h0, 1, 0, 8'h51, 16'h0000, 16'h0, 2'b00, 0, 16'h0, "t5_rst");
    releaseReset();
    applyStimulus(1, 1, 8'h52, 16'hFFFF, 16'h0, 1, 1, 8'h53, 16'hFFFF, 16'h0, 2'b10, 0, 16'h0, "t5_after");
    idleCycle("idle4");
    idleCycle("idle5");

    checkOutput("rd_queue_empty", 64'(rdQ.size()), 64'h0);
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
